// File: rtl/mem_fill_check_master.sv
// Avalon-MM master that fills a memory region with a pattern, then reads it back and verifies it.
// Optional MEM_FILL_CHECK_LFSR_EN selects a Galois LFSR pattern instead of seed + i.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | one write per cycle on the bus
// CHECK | one read per cycle; compares retire RD_LAT cycles later
// DRAIN | last RD_LAT compares still outstanding
// DONE  | one-cycle done pulse; results held until next start
module mem_fill_check_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                do_fill_i,
  input  logic                do_check_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     word_count_i,
  input  logic [DATA_W-1:0]   seed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ADDR_W:0]     err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W/8-1:0] byteenable_o,
  output logic                chipselect_o,
  output logic                clken_o,
  output logic                write_o,
  output logic [DATA_W-1:0]   writedata_o,
  input  logic [DATA_W-1:0]   readdata_i
);
  localparam int CW = ADDR_W + 1;
  localparam int BW = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;

`ifdef MEM_FILL_CHECK_LFSR_EN
  localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(32'h80200003);
  function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
    return (s == '0) ? '1 : s;
  endfunction
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] x);
    return {1'b0, x[DATA_W-1:1]} ^ (x[0] ? LFSR_MASK : '0);
  endfunction
`else
  function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
    return s;
  endfunction
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] x);
    return x + DATA_W'(1);
  endfunction
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       rem_q, rem_d, count_q, count_d, err_q, err_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d, first_q, first_d;
  logic [DATA_W-1:0]   seed_q, seed_d, pat_q, pat_d;
  logic                chk_q, chk_d, cs_q, cs_d, wr_q, wr_d, pass_q, pass_d;
  logic                abort_end, flush, push, mismatch;

  logic                pv_q [RD_LAT];
  logic [ADDR_W-1:0]   pa_q [RD_LAT];
  logic [DATA_W-1:0]   pe_q [RD_LAT];

  assign flush    = abort_i && (state_q == S_FILL || state_q == S_CHECK || state_q == S_DRAIN);
  assign push     = (state_q == S_CHECK) && !abort_i;
  assign mismatch = pv_q[RD_LAT-1] && !flush && (readdata_i != pe_q[RD_LAT-1]);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    count_d   = count_q;
    dcnt_d    = dcnt_q;
    base_d    = base_q;
    seed_d    = seed_q;
    chk_d     = chk_q;
    addr_d    = addr_q;
    pat_d     = pat_q;
    cs_d      = 1'b0;
    wr_d      = 1'b0;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    abort_end = 1'b0;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + CW'(1);
      if (err_q == '0) first_d = pa_q[RD_LAT-1];
    end

    case (state_q)
      S_IDLE: if (start_i) begin
        base_d  = base_addr_i;
        count_d = word_count_i;
        seed_d  = pat_first(seed_i);
        chk_d   = do_check_i;
        err_d   = '0;
        first_d = '0;
        pass_d  = 1'b0;
        if (word_count_i == '0 || !(do_fill_i || do_check_i)) begin
          state_d = S_DONE;
        end else begin
          cs_d    = 1'b1;
          wr_d    = do_fill_i;
          addr_d  = base_addr_i;
          pat_d   = pat_first(seed_i);
          rem_d   = word_count_i - CW'(1);
          state_d = do_fill_i ? S_FILL : S_CHECK;
        end
      end
      S_FILL: begin
        if (abort_i) begin
          state_d   = S_DONE;
          abort_end = 1'b1;
        end else if (rem_q != '0) begin
          cs_d   = 1'b1;
          wr_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          pat_d  = pat_next(pat_q);
          rem_d  = rem_q - CW'(1);
        end else if (chk_q) begin
          // Back-to-back turnaround: first read directly follows the last write.
          cs_d    = 1'b1;
          addr_d  = base_q;
          pat_d   = seed_q;
          rem_d   = count_q - CW'(1);
          state_d = S_CHECK;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        if (abort_i) begin
          state_d   = S_DONE;
          abort_end = 1'b1;
        end else if (rem_q != '0) begin
          cs_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          pat_d  = pat_next(pat_q);
          rem_d  = rem_q - CW'(1);
        end else begin
          dcnt_d  = 2'(RD_LAT - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d   = S_DONE;
          abort_end = 1'b1;
        end else if (dcnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == '0) && !abort_end;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      count_q <= '0;
      dcnt_q  <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      chk_q   <= 1'b0;
      addr_q  <= '0;
      pat_q   <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      dcnt_q  <= dcnt_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= push;
      pa_q[0] <= addr_q;
      pe_q[0] <= pat_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1] && !flush;
        pa_q[i] <= pa_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign clken_o          = busy_o;
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign address_o        = addr_q;
  assign chipselect_o     = cs_q;
  assign write_o          = wr_q;
  assign writedata_o      = pat_q;
  assign byteenable_o     = {BW{cs_q}};

endmodule

// File: tb/tb_mem_fill_check_master.sv
// Directed bench for mem_fill_check_master: RD_LAT=1 instance for the main scenarios, RD_LAT=2 instance for regression.
`timescale 1ns/1ps
module tb_mem_fill_check_master;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        st1, ab1, df1, dc1, busy1, done1, pass1, cs1, ck1, wr1;
  logic [9:0]  base1, ferr1, addr1;
  logic [10:0] cnt1, err1;
  logic [31:0] seed1, wd1, rdd1;
  logic [3:0]  be1;

  logic        st2, ab2, df2, dc2, busy2, done2, pass2, cs2, ck2, wr2;
  logic [9:0]  base2, ferr2, addr2;
  logic [10:0] cnt2, err2;
  logic [31:0] seed2, wd2, rdd2, rd2a;
  logic [3:0]  be2;

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  bit fault1 = 1'b0;
  bit fault2 = 1'b0;
  int cs_cnt1 = 0;

  mem_fill_check_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(st1), .abort_i(ab1),
    .do_fill_i(df1), .do_check_i(dc1), .base_addr_i(base1), .word_count_i(cnt1),
    .seed_i(seed1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_count_o(err1), .first_err_addr_o(ferr1), .address_o(addr1),
    .byteenable_o(be1), .chipselect_o(cs1), .clken_o(ck1), .write_o(wr1),
    .writedata_o(wd1), .readdata_i(rdd1));

  mem_fill_check_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(st2), .abort_i(ab2),
    .do_fill_i(df2), .do_check_i(dc2), .base_addr_i(base2), .word_count_i(cnt2),
    .seed_i(seed2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(err2), .first_err_addr_o(ferr2), .address_o(addr2),
    .byteenable_o(be2), .chipselect_o(cs2), .clken_o(ck2), .write_o(wr2),
    .writedata_o(wd2), .readdata_i(rdd2));

  // Memory models: corruption flips one bit on reads of words 5 and 9.
  always @(posedge clk) begin
    if (cs1) cs_cnt1 <= cs_cnt1 + 1;
    if (cs1 && ck1 && wr1) mem1[addr1] <= wd1;
    rdd1 <= (cs1 && !wr1) ?
            (mem1[addr1] ^ ((fault1 && (addr1 == 10'd5 || addr1 == 10'd9)) ? 32'h100 : 32'h0)) : 32'h0;
  end

  always @(posedge clk) begin
    if (cs2 && ck2 && wr2) mem2[addr2] <= wd2;
    rd2a <= (cs2 && !wr2) ?
            (mem2[addr2] ^ ((fault2 && (addr2 == 10'd5 || addr2 == 10'd9)) ? 32'h100 : 32'h0)) : 32'h0;
    rdd2 <= rd2a;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run1(input logic [9:0] base, input logic [10:0] cnt, input logic [31:0] seed,
                      input logic f, input logic c, input logic [10:0] e_err,
                      input logic [9:0] e_first, input logic e_pass, input logic glitch);
    int k;
    int exp_lat;
    int ncs;
    logic [9:0]  a;
    logic [31:0] d;
    exp_lat = (cnt == 0) ? 0 : ((f ? int'(cnt) : 0) + (c ? int'(cnt) + 1 : 0));
    ncs = cs_cnt1;
    @(negedge clk);
    st1 = 1'b1; df1 = f; dc1 = c; base1 = base; cnt1 = cnt; seed1 = seed;
    @(negedge clk);
    st1 = 1'b0;
    k = 0;
    if (cnt != 0 && f) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = base + 10'(i);
        d = seed + 32'(i);
        chk("fill_cs", cs1, 1);
        chk("fill_we", wr1, 1);
        chk("fill_addr", addr1, a);
        chk("fill_data", wd1, d);
        chk("fill_be", be1, 4'hF);
        chk("fill_busy", busy1, 1);
        if (glitch && i == 2) begin
          st1 = 1'b1; base1 = 10'd500; seed1 = 32'h5555;
        end else begin
          st1 = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    if (cnt != 0 && c) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = base + 10'(i);
        chk("rd_cs", cs1, 1);
        chk("rd_we", wr1, 0);
        chk("rd_addr", addr1, a);
        @(negedge clk);
        k++;
      end
    end
    while (done1 !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_lat", k, exp_lat);
    chk("pass", pass1, e_pass);
    chk("err_count", err1, e_err);
    chk("first_err", ferr1, e_first);
    chk("done_cs", cs1, 0);
    if (cnt == 0 || !(f || c)) chk("no_access", 64'(cs_cnt1 - ncs), 0);
    @(negedge clk);
    chk("done_pulse", done1, 0);
    chk("idle_busy", busy1, 0);
    chk("pass_hold", pass1, e_pass);
    chk("err_hold", err1, e_err);
  endtask

  initial begin
    int k;
    int dcount;
    reset_n = 1'b0;
    st1 = 0; ab1 = 0; df1 = 0; dc1 = 0; base1 = 0; cnt1 = 0; seed1 = 0;
    st2 = 0; ab2 = 0; df2 = 0; dc2 = 0; base2 = 0; cnt2 = 0; seed2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);
    chk("rst_first", ferr1, 0);
    chk("rst_cs", cs1, 0);
    chk("rst_clken", ck1, 0);
    chk("rst_we", wr1, 0);
    chk("rst_be", be1, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run1(10'd0, 11'd16, 32'h1000, 1, 1, 11'd0, 10'd0, 1, 1);
    run1(10'd0, 11'd16, 32'h1000, 0, 1, 11'd0, 10'd0, 1, 0);
    run1(10'd0, 11'd4, 32'h1001, 0, 1, 11'd4, 10'd0, 0, 0);
    run1(10'd1020, 11'd8, 32'hA0, 1, 1, 11'd0, 10'd0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_mem", mem1[(1020 + i) % 1024], 32'hA0 + 32'(i));
    end
    fault1 = 1'b1;
    run1(10'd0, 11'd16, 32'h2000, 1, 1, 11'd2, 10'd5, 0, 0);
    fault1 = 1'b0;
    run1(10'd0, 11'd0, 32'h1, 1, 1, 11'd0, 10'd0, 1, 0);
    run1(10'd100, 11'd8, 32'h1, 0, 0, 11'd0, 10'd0, 1, 0);
    run1(10'd200, 11'd5, 32'hFFFF_FFFE, 1, 0, 11'd0, 10'd0, 1, 0);

    // Abort three cycles into CHECK
    @(negedge clk);
    st1 = 1; df1 = 1; dc1 = 1; base1 = 0; cnt1 = 11'd64; seed1 = 32'h3000;
    @(negedge clk);
    st1 = 0;
    repeat (64) @(negedge clk);
    chk("ab_rd_cs", cs1, 1);
    chk("ab_rd_we", wr1, 0);
    @(negedge clk);
    @(negedge clk);
    ab1 = 1;
    @(negedge clk);
    ab1 = 0;
    chk("abort_cs", cs1, 0);
    chk("abort_done", done1, 1);
    chk("abort_pass", pass1, 0);
    chk("abort_err", err1, 0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    chk("abort_one_done", dcount, 0);

    // Abort in IDLE, then abort together with start
    ab1 = 1;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", busy1, 0);
    chk("idle_abort_cs", cs1, 0);
    st1 = 1; df1 = 1; dc1 = 0; base1 = 10'd40; cnt1 = 11'd4; seed1 = 32'h77;
    @(negedge clk);
    st1 = 0; ab1 = 0;
    chk("start_wins_busy", busy1, 1);
    chk("start_wins_cs", cs1, 1);
    chk("start_wins_addr", addr1, 10'd40);
    k = 0;
    while (done1 !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("start_wins_lat", k, 4);
    chk("start_wins_pass", pass1, 1);

    // Reset mid-fill
    @(negedge clk);
    st1 = 1; df1 = 1; dc1 = 1; base1 = 0; cnt1 = 11'd64; seed1 = 32'h9000;
    @(negedge clk);
    st1 = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_cs", cs1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_cs", cs1, 0);
    chk("arst_we", wr1, 0);
    chk("arst_addr", addr1, 0);
    chk("arst_data", wd1, 0);
    chk("arst_clken", ck1, 0);
    chk("arst_be", be1, 0);
    @(negedge clk);
    st1 = 1;
    @(negedge clk);
    st1 = 0;
    chk("rst_start_busy", busy1, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_cs", cs1, 0);

    // RD_LAT = 2 instance
    for (int r = 0; r < 2; r++) begin
      fault2 = (r == 1);
      @(negedge clk);
      st2 = 1; df2 = 1; dc2 = 1; base2 = 0; cnt2 = 11'd16; seed2 = 32'h1000;
      @(negedge clk);
      st2 = 0;
      chk("l2_first_addr", addr2, 0);
      chk("l2_first_data", wd2, 32'h1000);
      k = 0;
      while (done2 !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("l2_done_lat", k, 34);
      chk("l2_pass", pass2, (r == 0) ? 1 : 0);
      chk("l2_err", err2, (r == 0) ? 0 : 2);
      chk("l2_first_err", ferr2, (r == 0) ? 0 : 5);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
